snr_gate_controller: RTL and testbench
======================================

Name: snr_gate_controller

Overview:
- Sits downstream of snr_calculator and closes the loop with it.
- Drives snr_calculator's quiet_period input to run a timed noise-calibration window after reset or on request.
- Consumes the snr_db stream over a valid/ready handshake and produces a debounced, hysteretic gate_active flag that enables pitch detection only on real signal.

Parameters:
- SNR_WIDTH, 16, width of snr_db; signed two's complement, Q8.8 dB.
- DATA_WIDTH, 16, width of noise_rms.
- CAL_SAMPLES, 4096, audio samples counted with quiet_period high; must be >= 1.
- SETTLE_SAMPLES, 256, audio samples after calibration during which SNR is accepted and discarded; 0 means skip SETTLE.
- ON_THRESH, 3072, Q8.8 SNR at or above which a sample counts toward opening the gate (12 dB).
- OFF_THRESH, 1536, Q8.8 SNR below which a sample counts toward closing the gate (6 dB); must be <= ON_THRESH.
- HOLD_COUNT, 8, consecutive qualifying accepted SNR samples needed to toggle the gate; must be >= 1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- recal_req  in  1  single-cycle request to restart calibration.
- audio_valid  in  1  audio sample strobe, the same strobe fed to snr_calculator's audio_input_valid.
- noise_rms  in  DATA_WIDTH  noise RMS from snr_calculator.
- snr_db  in  SNR_WIDTH  signed Q8.8 SNR.
- snr_valid  in  1  snr_db valid.
- snr_ready  out  1  accept snr_db.
- quiet_period  out  1  high while calibrating the noise floor.
- cal_done  out  1  high once the first calibration has completed; stays high through recalibration.
- cal_fault  out  1  noise_rms was 0 at the end of the last calibration.
- gate_active  out  1  debounced signal-present flag.
- gate_change  out  1  one-cycle pulse on every gate_active toggle.
- state_o  out  2  current FSM state, for debug.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to CALIBRATE.
  - Outputs: quiet_period=1, snr_ready=0, cal_done=0, cal_fault=0, gate_active=0, gate_change=0.
  - All counters cleared.
- States: CALIBRATE=0, SETTLE=1, MONITOR=2. Encoding 3 is unused and recovers to CALIBRATE on the next edge.
- CALIBRATE:
  - Outputs: quiet_period=1, snr_ready=0, gate_active forced 0.
  - sample_cnt increments on each audio_valid.
  - On the edge where audio_valid && sample_cnt==CAL_SAMPLES-1:
    - cal_fault <= (noise_rms==0);
    - cal_done <= 1;
    - sample_cnt <= 0;
    - next state is SETTLE, or MONITOR if SETTLE_SAMPLES==0.
- SETTLE:
  - Outputs: quiet_period=0, snr_ready=1; accepted SNR samples are discarded.
  - sample_cnt counts audio_valid; go to MONITOR on the edge where audio_valid && sample_cnt==SETTLE_SAMPLES-1.
- MONITOR:
  - Outputs: quiet_period=0, snr_ready=1.
  - A sample is accepted on snr_valid && snr_ready; hysteresis is evaluated only on accepted samples.
  - Comparisons are signed, full SNR_WIDTH.
  - Gate closed:
    - snr_db >= ON_THRESH: hold_cnt++.
    - Otherwise: hold_cnt <= 0.
    - When the accepted sample makes the streak reach HOLD_COUNT: gate_active <= 1 on that edge and hold_cnt <= 0.
  - Gate open:
    - snr_db < OFF_THRESH: hold_cnt++.
    - Otherwise: hold_cnt <= 0.
    - Reaching HOLD_COUNT: gate_active <= 0 and hold_cnt <= 0.
  - gate_change is registered high for exactly one cycle after any gate_active toggle.
  - With cal_fault=1, gate_active is held 0 and hold_cnt stays 0; the FSM remains in MONITOR until recal_req.
- recal_req, any state:
  - Next state is CALIBRATE and sample_cnt/hold_cnt are cleared.
  - If the gate was open: gate_active <= 0 and gate_change pulses.
  - recal_req during CALIBRATE restarts the window.
  - recal_req wins over a simultaneous CALIBRATE-exit or hysteresis toggle.
- Latency: gate_active is visible the cycle after the edge accepting the HOLD_COUNT-th qualifying sample. quiet_period falls the cycle after the last calibration sample.
- Widths:
  - sample_cnt width is $clog2(max(CAL_SAMPLES,SETTLE_SAMPLES)+1).
  - hold_cnt width is $clog2(HOLD_COUNT+1).
  - Neither counter ever wraps.
- snr_valid while snr_ready=0 is ignored; no buffering.

Decomposition:
- Package snr_gate_pkg holds:
  - typedef enum logic [1:0] gate_state_t {CALIBRATE, SETTLE, MONITOR};
  - localparam SNR_FRAC=8;
  - helper function db_to_q8(int).
- One natural sub-module, snr_hysteresis: comparator plus hold counter plus gate register, with inputs sample_en, snr, clear and output gate. The top level keeps the FSM and sample counters.

Test Plan:
- Reset release, CAL_SAMPLES=16, 16 audio_valid pulses with noise_rms=100 -> quiet_period high for exactly 16 samples, then low; cal_done=1, cal_fault=0; state SETTLE then MONITOR after SETTLE_SAMPLES pulses.
- MONITOR, HOLD_COUNT=8, 8 accepted snr_db=3072 -> gate_active=1 after the 8th; gate_change one pulse. 7 at 3072 then 1 at 3071 -> gate stays 0.
- Gate open, snr_db alternating 1535/2000 -> never closes. 8 consecutive 1535 -> closes with one gate_change pulse.
- snr_db=-32768 and +32767 -> treated as signed; closes / opens correctly.
- noise_rms=0 at calibration end -> cal_fault=1; snr_db=10000 x20 keeps gate_active=0. recal_req with noise_rms=50 -> cal_fault clears at the next calibration end.
- Gate open, recal_req coincident with the 8th closing sample -> CALIBRATE next cycle, quiet_period=1, single gate_change pulse. Async reset asserted mid-SETTLE -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/snr_gate_pkg.sv
// Shared types and helpers for the SNR gate controller and its hysteresis block.
package snr_gate_pkg;

   typedef enum logic [1:0] {
      CALIBRATE = 2'd0,
      SETTLE    = 2'd1,
      MONITOR   = 2'd2
   } gate_state_t;

   localparam int SNR_FRAC = 8;

   // Whole dB to signed Q8.8.
   function automatic int db_to_q8(input int db);
      return db * (1 << SNR_FRAC);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/snr_hysteresis.sv
// Debounced hysteresis gate: opens after HOLD_COUNT consecutive accepted samples at or
// above ON_THRESH, closes after HOLD_COUNT consecutive accepted samples below OFF_THRESH.
module snr_hysteresis
   import snr_gate_pkg::*;
#(
   parameter int SNR_WIDTH  = 16,
   parameter int ON_THRESH  = db_to_q8(12),
   parameter int OFF_THRESH = db_to_q8(6),
   parameter int HOLD_COUNT = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        sample_en,
   input  logic signed [SNR_WIDTH-1:0] snr,
   input  logic                        clear,
   output logic                        gate,
   output logic                        change
);

   localparam int HW = $clog2(HOLD_COUNT + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_COUNT - 1);
   localparam logic signed [SNR_WIDTH-1:0] ON_Q  = SNR_WIDTH'(ON_THRESH);
   localparam logic signed [SNR_WIDTH-1:0] OFF_Q = SNR_WIDTH'(OFF_THRESH);

   logic          gate_reg;
   logic          change_reg;
   logic [HW-1:0] hold_reg;
   logic          qualify;

   // The threshold that matters depends on which way the gate would toggle.
   always_comb begin
      qualify = gate_reg ? (snr < OFF_Q) : (snr >= ON_Q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gate_reg   <= 1'b0;
         change_reg <= 1'b0;
         hold_reg   <= '0;
      end else if (clear) begin
         // Forced close still reports a toggle if the gate was open.
         hold_reg   <= '0;
         gate_reg   <= 1'b0;
         change_reg <= gate_reg;
      end else if (sample_en && qualify) begin
         if (hold_reg == HOLD_LAST) begin
            hold_reg   <= '0;
            gate_reg   <= ~gate_reg;
            change_reg <= 1'b1;
         end else begin
            hold_reg   <= hold_reg + HW'(1);
            change_reg <= 1'b0;
         end
      end else begin
         if (sample_en) begin
            hold_reg <= '0;
         end
         change_reg <= 1'b0;
      end
   end

   assign gate   = gate_reg;
   assign change = change_reg;

endmodule

// File: rtl/snr_gate_controller.sv
// Runs the noise-calibration window for snr_calculator, discards the settling SNR samples,
// then drives a debounced, hysteretic signal-present gate from the snr_db stream.
module snr_gate_controller
   import snr_gate_pkg::*;
#(
   parameter int SNR_WIDTH      = 16,
   parameter int DATA_WIDTH     = 16,
   parameter int CAL_SAMPLES    = 4096,
   parameter int SETTLE_SAMPLES = 256,
   parameter int ON_THRESH      = db_to_q8(12),
   parameter int OFF_THRESH     = db_to_q8(6),
   parameter int HOLD_COUNT     = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        recal_req,
   input  logic                        audio_valid,
   input  logic [DATA_WIDTH-1:0]       noise_rms,
   input  logic signed [SNR_WIDTH-1:0] snr_db,
   input  logic                        snr_valid,
   output logic                        snr_ready,
   output logic                        quiet_period,
   output logic                        cal_done,
   output logic                        cal_fault,
   output logic                        gate_active,
   output logic                        gate_change,
   output logic [1:0]                  state_o
);

   localparam int CW = $clog2(max_int(CAL_SAMPLES, SETTLE_SAMPLES) + 1);
   localparam logic [CW-1:0] CAL_LAST    = CW'(CAL_SAMPLES - 1);
   localparam logic [CW-1:0] SETTLE_LAST = (SETTLE_SAMPLES > 0) ? CW'(SETTLE_SAMPLES - 1) : '0;

   gate_state_t   state_reg;
   logic [CW-1:0] sample_cnt_reg;
   logic          quiet_reg;
   logic          ready_reg;
   logic          cal_done_reg;
   logic          cal_fault_reg;
   logic          sample_en;
   logic          hyst_clear;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= CALIBRATE;
         sample_cnt_reg <= '0;
         quiet_reg      <= 1'b1;
         ready_reg      <= 1'b0;
         cal_done_reg   <= 1'b0;
         cal_fault_reg  <= 1'b0;
      end else if (recal_req) begin
         // A request overrides whatever exit the current state would have taken.
         state_reg      <= CALIBRATE;
         sample_cnt_reg <= '0;
         quiet_reg      <= 1'b1;
         ready_reg      <= 1'b0;
      end else begin
         case (state_reg)
            CALIBRATE: begin
               if (audio_valid) begin
                  if (sample_cnt_reg == CAL_LAST) begin
                     cal_fault_reg  <= (noise_rms == '0);
                     cal_done_reg   <= 1'b1;
                     sample_cnt_reg <= '0;
                     state_reg      <= (SETTLE_SAMPLES == 0) ? MONITOR : SETTLE;
                     quiet_reg      <= 1'b0;
                     ready_reg      <= 1'b1;
                  end else begin
                     sample_cnt_reg <= sample_cnt_reg + CW'(1);
                  end
               end
            end
            SETTLE: begin
               if (audio_valid) begin
                  if (sample_cnt_reg == SETTLE_LAST) begin
                     sample_cnt_reg <= '0;
                     state_reg      <= MONITOR;
                  end else begin
                     sample_cnt_reg <= sample_cnt_reg + CW'(1);
                  end
               end
            end
            MONITOR: begin
               sample_cnt_reg <= '0;
            end
            default: begin
               state_reg      <= CALIBRATE;
               sample_cnt_reg <= '0;
               quiet_reg      <= 1'b1;
               ready_reg      <= 1'b0;
            end
         endcase
      end
   end

   // A faulted calibration keeps the gate shut until the next recalibration.
   assign sample_en  = snr_valid && ready_reg && (state_reg == MONITOR);
   assign hyst_clear = recal_req || (state_reg != MONITOR) || cal_fault_reg;

   snr_hysteresis #(
      .SNR_WIDTH (SNR_WIDTH),
      .ON_THRESH (ON_THRESH),
      .OFF_THRESH(OFF_THRESH),
      .HOLD_COUNT(HOLD_COUNT)
   ) u_hysteresis (
      .clk      (clk),
      .reset    (reset),
      .sample_en(sample_en),
      .snr      (snr_db),
      .clear    (hyst_clear),
      .gate     (gate_active),
      .change   (gate_change)
   );

   assign snr_ready    = ready_reg;
   assign quiet_period = quiet_reg;
   assign cal_done     = cal_done_reg;
   assign cal_fault    = cal_fault_reg;
   assign state_o      = state_reg;

endmodule

// File: tb/tb_snr_gate_controller.sv
// Self-checking bench: calibration flow, table-driven hysteresis vectors, randomized
// stream against a sliding-window model, and fault / recalibration / reset corner cases.
module tb_snr_gate_controller;

   localparam int CAL    = 16;
   localparam int SETTLE = 4;
   localparam int HOLD   = 8;
   localparam int ON     = 3072;
   localparam int OFF    = 1536;

   logic               clk = 1'b0;
   logic               reset;
   logic               recal_req;
   logic               audio_valid;
   logic [15:0]        noise_rms;
   logic signed [15:0] snr_db;
   logic               snr_valid;
   logic               snr_ready;
   logic               quiet_period;
   logic               cal_done;
   logic               cal_fault;
   logic               gate_active;
   logic               gate_change;
   logic [1:0]         state_o;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic valid;
      int   snr;
      logic exp_gate;
      logic exp_change;
   } vec_t;

   vec_t vecs[$];

   // Reference model: accepted samples since the last toggle.
   logic model_gate;
   int   model_q[$];

   always #5 clk = ~clk;

   snr_gate_controller #(
      .SNR_WIDTH     (16),
      .DATA_WIDTH    (16),
      .CAL_SAMPLES   (CAL),
      .SETTLE_SAMPLES(SETTLE),
      .ON_THRESH     (ON),
      .OFF_THRESH    (OFF),
      .HOLD_COUNT    (HOLD)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .recal_req   (recal_req),
      .audio_valid (audio_valid),
      .noise_rms   (noise_rms),
      .snr_db      (snr_db),
      .snr_valid   (snr_valid),
      .snr_ready   (snr_ready),
      .quiet_period(quiet_period),
      .cal_done    (cal_done),
      .cal_fault   (cal_fault),
      .gate_active (gate_active),
      .gate_change (gate_change),
      .state_o     (state_o)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic v, input int s, input logic g, input logic c);
      vec_t e;
      e.valid      = v;
      e.snr        = s;
      e.exp_gate   = g;
      e.exp_change = c;
      vecs.push_back(e);
   endtask

   task automatic audio_pulse();
      audio_valid = 1'b1;
      tick();
      audio_valid = 1'b0;
      tick();
   endtask

   task automatic run_cal(input int rms);
      noise_rms = 16'(rms);
      for (int i = 0; i < CAL; i++) begin
         audio_pulse();
         if (i < CAL - 1) chk("cal_quiet_high", quiet_period, 1);
      end
      chk("cal_end_quiet_low", quiet_period, 0);
      chk("cal_end_done", cal_done, 1);
      chk("cal_end_fault", cal_fault, (rms == 0) ? 1 : 0);
   endtask

   task automatic run_settle();
      for (int i = 0; i < SETTLE; i++) begin
         audio_pulse();
         chk("settle_state", state_o, (i < SETTLE - 1) ? 1 : 2);
      end
   endtask

   task automatic send(input int s, input logic g, input logic c, input string name);
      snr_valid = 1'b1;
      snr_db    = 16'(s);
      tick();
      snr_valid = 1'b0;
      chk(name, gate_active, g);
      chk({name, "_chg"}, gate_change, c);
      $display("txn %s snr=%0d gate=%0d change=%0d", name, s, gate_active, gate_change);
   endtask

   function automatic logic qualifies(input logic g, input int s);
      return g ? (s < OFF) : (s >= ON);
   endfunction

   // Toggle when the newest HOLD accepted samples since the last toggle all qualify.
   task automatic model_step(input logic v, input int s, output logic toggled);
      logic all_q;
      toggled = 1'b0;
      if (v) begin
         model_q.push_back(s);
         if (model_q.size() >= HOLD) begin
            all_q = 1'b1;
            for (int k = model_q.size() - HOLD; k < model_q.size(); k++)
               if (!qualifies(model_gate, model_q[k])) all_q = 1'b0;
            if (all_q) begin
               model_gate = ~model_gate;
               model_q.delete();
               toggled = 1'b1;
            end
         end
      end
   endtask

   initial begin
      logic tog;
      int   s;
      logic v;

      reset       = 1'b0;
      recal_req   = 1'b0;
      audio_valid = 1'b0;
      noise_rms   = 16'd0;
      snr_db      = '0;
      snr_valid   = 1'b0;
      repeat (3) tick();
      chk("rst_quiet", quiet_period, 1);
      chk("rst_ready", snr_ready, 0);
      chk("rst_done", cal_done, 0);
      chk("rst_fault", cal_fault, 0);
      chk("rst_gate", gate_active, 0);
      chk("rst_change", gate_change, 0);
      chk("rst_state", state_o, 0);
      reset = 1'b1;
      tick();

      // Calibration and settle flow
      run_cal(100);
      chk("cal_state_settle", state_o, 1);
      chk("cal_ready", snr_ready, 1);
      run_settle();

      // Table-driven hysteresis vectors
      for (int i = 0; i < 7; i++) add(1, 3072, 0, 0);
      add(1, 3071, 0, 0);
      for (int i = 0; i < 4; i++) add(1, 3072, 0, 0);
      add(0, -100, 0, 0);
      for (int i = 0; i < 3; i++) add(1, 3072, 0, 0);
      add(1, 3072, 1, 1);
      add(1, 3072, 1, 0);
      for (int i = 0; i < 5; i++) begin
         add(1, 1535, 1, 0);
         add(1, 2000, 1, 0);
      end
      for (int i = 0; i < 7; i++) add(1, 1535, 1, 0);
      add(1, 1535, 0, 1);
      for (int i = 0; i < 7; i++) add(1, 32767, 0, 0);
      add(1, 32767, 1, 1);
      for (int i = 0; i < 7; i++) add(1, -32768, 1, 0);
      add(1, -32768, 0, 1);
      add(1, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         snr_valid = vecs[i].valid;
         snr_db    = 16'(vecs[i].snr);
         tick();
         chk($sformatf("vec%0d_gate", i), gate_active, vecs[i].exp_gate);
         chk($sformatf("vec%0d_chg", i), gate_change, vecs[i].exp_change);
         $display("txn vec%0d valid=%0d snr=%0d gate=%0d change=%0d", i, vecs[i].valid,
                  vecs[i].snr, gate_active, gate_change);
      end
      snr_valid = 1'b0;

      // Randomized stream against the reference model
      model_gate = 1'b0;
      model_q.delete();
      for (int cyc = 0; cyc < 600; cyc++) begin
         v = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 9))
            0: s = ON - 1;
            1: s = ON;
            2: s = OFF - 1;
            3: s = OFF;
            4: s = int'($urandom_range(0, 65535)) - 32768;
            default:
               s = ((cyc / 50) % 2 == 0) ? int'($urandom_range(3072, 32767))
                                         : int'($urandom_range(0, 34303)) - 32768;
         endcase
         snr_valid   = v;
         snr_db      = 16'(s);
         audio_valid = $urandom_range(0, 1) != 0;
         tick();
         model_step(v, s, tog);
         chk("rnd_gate", gate_active, model_gate);
         chk("rnd_chg", gate_change, tog);
         $display("txn rnd%0d valid=%0d snr=%0d gate=%0d change=%0d", cyc, v, s,
                  gate_active, gate_change);
      end
      snr_valid   = 1'b0;
      audio_valid = 1'b0;

      // Recalibrate into a faulted noise floor
      recal_req = 1'b1;
      tick();
      recal_req = 1'b0;
      chk("recal1_state", state_o, 0);
      chk("recal1_quiet", quiet_period, 1);
      chk("recal1_gate", gate_active, 0);
      chk("recal1_chg", gate_change, model_gate);
      chk("recal1_done_kept", cal_done, 1);
      run_cal(0);
      run_settle();
      for (int i = 0; i < 20; i++) send(10000, 0, 0, "fault_hold");
      chk("fault_state", state_o, 2);

      // Recalibrate with a healthy noise floor, then open the gate
      recal_req = 1'b1;
      tick();
      recal_req = 1'b0;
      chk("recal2_fault_kept", cal_fault, 1);
      run_cal(50);
      run_settle();
      for (int i = 0; i < 7; i++) send(3072, 0, 0, "open");
      send(3072, 1, 1, "open_last");

      // recal_req coincident with the closing sample
      for (int i = 0; i < 7; i++) send(1535, 1, 0, "close");
      snr_valid = 1'b1;
      snr_db    = 16'(1535);
      recal_req = 1'b1;
      tick();
      snr_valid = 1'b0;
      recal_req = 1'b0;
      chk("race_state", state_o, 0);
      chk("race_quiet", quiet_period, 1);
      chk("race_gate", gate_active, 0);
      chk("race_chg", gate_change, 1);
      tick();
      chk("race_chg_single", gate_change, 0);
      $display("txn recal_race state=%0d gate=%0d", state_o, gate_active);

      // Asynchronous reset in the middle of SETTLE
      run_cal(100);
      audio_pulse();
      audio_pulse();
      chk("mid_settle_state", state_o, 1);
      #2 reset = 1'b0;
      #1;
      chk("arst_quiet", quiet_period, 1);
      chk("arst_ready", snr_ready, 0);
      chk("arst_done", cal_done, 0);
      chk("arst_fault", cal_fault, 0);
      chk("arst_gate", gate_active, 0);
      chk("arst_change", gate_change, 0);
      chk("arst_state", state_o, 0);
      tick();
      reset = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
